// File: rtl/apb_master_bridge.sv
// Single-outstanding APB initiator: valid/ready request -> APB SETUP/ACCESS -> valid/ready response.
// Latency: psel 1 cycle after acceptance, penable 2, rsp_valid 3 (+1 per wait state); 4-cycle peak period.
// Backpressure: req_ready low from acceptance until the response handshake; the response is held until rsp_ready.
//
// Ports: clk/rstn (async active-low reset); req_* request stream in; rsp_* response stream out
// (rsp_err 00 ok, 01 slave error, 10 timeout); psel/penable/paddr/pwrite/pwdata/prdata/pready/pslverr APB.
module apb_master_bridge #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [AW-1:0] req_addr,
    input  logic          req_write,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic [1:0]    rsp_err,
    output logic          psel,
    output logic          penable,
    output logic [AW-1:0] paddr,
    output logic          pwrite,
    output logic [DW-1:0] pwdata,
    input  logic [DW-1:0] prdata,
    input  logic          pready,
    input  logic          pslverr
);

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    // Counter value on the last permitted wait cycle; unused when TIMEOUT is 0.
    localparam logic [CW-1:0] CNT_LAST  = (TIMEOUT < 1) ? '0 : CW'(TIMEOUT - 1);
    // Word-aligns the APB address (byte lanes [1:0] always zero).
    localparam logic [AW-1:0] ADDR_MASK = ~AW'(3);

    localparam logic [1:0] ERR_OK  = 2'b00;
    localparam logic [1:0] ERR_SLV = 2'b01;
    localparam logic [1:0] ERR_TMO = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_RESP
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] wait_cnt, wait_cnt_nxt;
    logic          req_ready_nxt;
    logic          rsp_valid_nxt;
    logic [DW-1:0] rsp_rdata_nxt;
    logic [1:0]    rsp_err_nxt;
    logic          psel_nxt;
    logic          penable_nxt;
    logic [AW-1:0] paddr_nxt;
    logic          pwrite_nxt;
    logic [DW-1:0] pwdata_nxt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            wait_cnt  <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= ERR_OK;
            psel      <= 1'b0;
            penable   <= 1'b0;
            paddr     <= '0;
            pwrite    <= 1'b0;
            pwdata    <= '0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_cnt_nxt;
            req_ready <= req_ready_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_rdata <= rsp_rdata_nxt;
            rsp_err   <= rsp_err_nxt;
            psel      <= psel_nxt;
            penable   <= penable_nxt;
            paddr     <= paddr_nxt;
            pwrite    <= pwrite_nxt;
            pwdata    <= pwdata_nxt;
        end
    end

    // Every output is a register; this block only computes their next values.
    always_comb begin
        state_nxt     = state;
        wait_cnt_nxt  = wait_cnt;
        req_ready_nxt = req_ready;
        rsp_valid_nxt = rsp_valid;
        rsp_rdata_nxt = rsp_rdata;
        rsp_err_nxt   = rsp_err;
        psel_nxt      = psel;
        penable_nxt   = penable;
        paddr_nxt     = paddr;
        pwrite_nxt    = pwrite;
        pwdata_nxt    = pwdata;

        case (state)
            ST_IDLE: begin
                // Coming out of reset req_ready is still 0, so nothing is
                // accepted until it has been raised for one clock.
                req_ready_nxt = 1'b1;
                if (req_valid && req_ready) begin
                    state_nxt     = ST_SETUP;
                    req_ready_nxt = 1'b0;
                    psel_nxt      = 1'b1;
                    penable_nxt   = 1'b0;
                    paddr_nxt     = req_addr & ADDR_MASK;
                    pwrite_nxt    = req_write;
                    pwdata_nxt    = req_write ? req_wdata : '0;
                    wait_cnt_nxt  = '0;
                end
            end

            ST_SETUP: begin
                state_nxt   = ST_ACCESS;
                penable_nxt = 1'b1;
            end

            ST_ACCESS: begin
                if (pready) begin
                    // pslverr only matters on the completing cycle.
                    state_nxt     = ST_RESP;
                    psel_nxt      = 1'b0;
                    penable_nxt   = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    rsp_err_nxt   = pslverr ? ERR_SLV : ERR_OK;
                    rsp_rdata_nxt = (!pwrite && !pslverr) ? prdata : '0;
                end else if ((TIMEOUT != 0) && (wait_cnt == CNT_LAST)) begin
                    // Stuck slave: give up; a late pready lands in RESP/IDLE and is ignored.
                    state_nxt     = ST_RESP;
                    psel_nxt      = 1'b0;
                    penable_nxt   = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    rsp_err_nxt   = ERR_TMO;
                    rsp_rdata_nxt = '0;
                end else if (TIMEOUT != 0) begin
                    wait_cnt_nxt = wait_cnt + 1'b1;
                end
            end

            ST_RESP: begin
                if (rsp_ready) begin
                    state_nxt     = ST_IDLE;
                    rsp_valid_nxt = 1'b0;
                    req_ready_nxt = 1'b1;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: table of transfers plus hand-written corner sequences.
// Latency: n/a (drives one transfer at a time, plays the APB slave cycle by cycle).
// Backpressure: exercises rsp_ready held low with a new request pending.
module tb_apb_master_bridge;

    localparam int TMO = 16;

    logic        clk;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_write;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;
    logic        psel;
    logic        penable;
    logic [31:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    apb_master_bridge #(.AW(32), .DW(32), .TIMEOUT(TMO)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_write (req_write),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .psel      (psel),
        .penable   (penable),
        .paddr     (paddr),
        .pwrite    (pwrite),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        int          waits;      // pready low cycles before the ready cycle
        logic        slverr;     // pslverr on the ready cycle
        logic        stuck;      // pready never rises
        logic [31:0] rdata;      // prdata the slave presents
        logic [31:0] exp_paddr;
        logic [31:0] exp_pwdata;
        logic [1:0]  exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  err;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[7];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents the request, waits (bounded) for acceptance; returns in the cycle after the acceptance edge.
    task automatic issue(input vec_t v, output int waited);
        exp_t e;
        req_valid = 1'b1;
        req_addr  = v.addr;
        req_write = v.wr;
        req_wdata = v.wdata;
        waited = 0;
        while (req_ready !== 1'b1 && waited < 50) begin
            step();
            waited++;
        end
        if (req_ready !== 1'b1) chk("accept_wait", {31'b0, req_ready}, 32'd1);
        step();
        e.rdata = v.exp_rdata;
        e.err   = v.exp_err;
        sb.push_back(e);
        req_valid = 1'b0;
        chk("req_ready_drop", {31'b0, req_ready}, 32'd0);
    endtask

    // Plays the slave through SETUP and ACCESS; returns in the first RESP cycle.
    task automatic apb_phase(input vec_t v);
        int acc;
        bit stable;
        int exp_acc;
        exp_acc = v.stuck ? TMO : v.waits + 1;
        chk("setup_psel", {31'b0, psel}, 32'd1);
        chk("setup_penable", {31'b0, penable}, 32'd0);
        chk("setup_paddr", paddr, v.exp_paddr);
        chk("setup_pwrite", {31'b0, pwrite}, {31'b0, v.wr});
        chk("setup_pwdata", pwdata, v.exp_pwdata);
        step();
        acc = 0;
        stable = 1'b1;
        while (penable === 1'b1 && acc < 40) begin
            if (psel !== 1'b1 || paddr !== v.exp_paddr || pwrite !== v.wr ||
                pwdata !== v.exp_pwdata || rsp_valid !== 1'b0) stable = 1'b0;
            pready  = !v.stuck && (acc == v.waits);
            // pslverr is high on wait cycles, where it must be ignored.
            pslverr = (!v.stuck && acc == v.waits) ? v.slverr : 1'b1;
            prdata  = v.rdata;
            acc++;
            step();
        end
        pready  = 1'b0;
        pslverr = 1'b0;
        prdata  = 32'hBAD0_BAD0;
        chk("access_cycles", acc, exp_acc);
        chk("access_stable", {31'b0, stable}, 32'd1);
        chk("resp_psel", {31'b0, psel}, 32'd0);
        chk("resp_penable", {31'b0, penable}, 32'd0);
        chk("resp_valid", {31'b0, rsp_valid}, 32'd1);
    endtask

    // Holds rsp_ready low for bp cycles, then completes the handshake against the scoreboard.
    task automatic respond(input int bp);
        exp_t        e;
        logic [31:0] r0;
        logic [1:0]  e0;
        bit          ok;
        rsp_ready = 1'b0;
        r0 = rsp_rdata;
        e0 = rsp_err;
        ok = 1'b1;
        for (int i = 0; i < bp; i++) begin
            step();
            if (rsp_valid !== 1'b1 || rsp_rdata !== r0 || rsp_err !== e0 ||
                req_ready !== 1'b0 || psel !== 1'b0) ok = 1'b0;
        end
        if (bp > 0) chk("bp_hold", {31'b0, ok}, 32'd1);
        if (sb.size() == 0) begin
            chk("sb_nonempty", sb.size(), 32'd1);
        end else begin
            e = sb.pop_front();
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_err", {30'b0, rsp_err}, {30'b0, e.err});
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("post_hs_valid", {31'b0, rsp_valid}, 32'd0);
        chk("post_hs_ready", {31'b0, req_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vb, vn, vs, vr;
        int   w;
        bit   quiet;

        //          addr           wr    wdata          waits slverr stuck rdata          paddr          pwdata         err    rdata
        vecs[0] = '{32'h0000_0008, 1'b1, 32'h0000_00FF, 0,    1'b0,  1'b0, 32'h0000_0099, 32'h0000_0008, 32'h0000_00FF, 2'b00, 32'h0};
        vecs[1] = '{32'h0000_0000, 1'b0, 32'hFFFF_FFFF, 3,    1'b0,  1'b0, 32'h0000_00A5, 32'h0000_0000, 32'h0,         2'b00, 32'h0000_00A5};
        vecs[2] = '{32'h0000_004C, 1'b1, 32'h1234_5678, 0,    1'b1,  1'b0, 32'h0,         32'h0000_004C, 32'h1234_5678, 2'b01, 32'h0};
        vecs[3] = '{32'h0000_0055, 1'b0, 32'h0,         1,    1'b0,  1'b0, 32'hDEAD_BEEF, 32'h0000_0054, 32'h0,         2'b00, 32'hDEAD_BEEF};
        vecs[4] = '{32'h0000_0030, 1'b0, 32'h0,         15,   1'b0,  1'b0, 32'h5A5A_0001, 32'h0000_0030, 32'h0,         2'b00, 32'h5A5A_0001};
        vecs[5] = '{32'h0000_0013, 1'b0, 32'h0,         99,   1'b0,  1'b1, 32'h0000_CAFE, 32'h0000_0010, 32'h0,         2'b10, 32'h0};
        vecs[6] = '{32'h0000_07FF, 1'b1, 32'hA5A5_A5A5, 2,    1'b1,  1'b0, 32'h0000_0777, 32'h0000_07FC, 32'hA5A5_A5A5, 2'b01, 32'h0};

        rstn      = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_write = 1'b0;
        req_wdata = '0;
        rsp_ready = 1'b0;
        prdata    = '0;
        pready    = 1'b0;
        pslverr   = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_psel", {31'b0, psel}, 32'd0);
        chk("rst_penable", {31'b0, penable}, 32'd0);
        chk("rst_paddr", paddr, 32'd0);
        chk("rst_pwrite", {31'b0, pwrite}, 32'd0);
        chk("rst_pwdata", pwdata, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", {30'b0, rsp_err}, 32'd0);
        rstn = 1'b1;
        #1;
        chk("rel_req_ready_before_clk", {31'b0, req_ready}, 32'd0);
        step();
        chk("rel_req_ready_first_clk", {31'b0, req_ready}, 32'd1);

        // Table-driven transfers
        for (int i = 0; i < 7; i++) begin
            issue(vecs[i], w);
            apb_phase(vecs[i]);
            respond(0);
        end

        // Response backpressure with the next request already waiting
        vb = '{32'h0000_0040, 1'b1, 32'h0000_0011, 0, 1'b0, 1'b0, 32'h0, 32'h0000_0040, 32'h0000_0011, 2'b00, 32'h0};
        vn = '{32'h0000_0044, 1'b0, 32'h0,         0, 1'b0, 1'b0, 32'h0000_0066, 32'h0000_0044, 32'h0, 2'b00, 32'h0000_0066};
        issue(vb, w);
        apb_phase(vb);
        req_valid = 1'b1;
        req_addr  = vn.addr;
        req_write = vn.wr;
        req_wdata = vn.wdata;
        respond(5);
        issue(vn, w);
        chk("accept_after_hs", w, 32'd0);
        apb_phase(vn);
        respond(0);

        // Timeout with a late pready: exactly one response
        vs = '{32'h0000_0020, 1'b0, 32'h0, 99, 1'b0, 1'b1, 32'h1111_2222, 32'h0000_0020, 32'h0, 2'b10, 32'h0};
        issue(vs, w);
        apb_phase(vs);
        pready = 1'b1;
        respond(2);
        quiet = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            if (rsp_valid !== 1'b0 || psel !== 1'b0) quiet = 1'b0;
        end
        pready = 1'b0;
        chk("late_pready_ignored", {31'b0, quiet}, 32'd1);

        // Reset in the middle of ACCESS
        vr = '{32'h0000_0100, 1'b0, 32'h0, 0, 1'b0, 1'b1, 32'h0, 32'h0000_0100, 32'h0, 2'b10, 32'h0};
        issue(vr, w);
        step();
        chk("pre_rst_penable", {31'b0, penable}, 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        chk("mid_rst_psel", {31'b0, psel}, 32'd0);
        chk("mid_rst_penable", {31'b0, penable}, 32'd0);
        chk("mid_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        sb.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        step();
        chk("rst_release_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_release_no_rsp", {31'b0, rsp_valid}, 32'd0);
        vr = '{32'h0000_0004, 1'b1, 32'h0000_003C, 0, 1'b0, 1'b0, 32'h0, 32'h0000_0004, 32'h0000_003C, 2'b00, 32'h0};
        issue(vr, w);
        apb_phase(vr);
        respond(0);

        chk("sb_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
